// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader.
// Takes a big-endian byte stream over valid/ready. The stream is a 16-bit word
// count N followed by 4*N data bytes. It packs each group of four bytes into a
// 32-bit word and writes it to the instruction memory at consecutive word
// addresses. It holds the core in reset until a load completes without error.
// Optional feature macro: PROG_LOADER_CHKSUM_EN. When defined, the loader
// accepts one trailing byte and checks it against the XOR of all data bytes.
module prog_loader #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Largest legal word count: the full capacity of the instruction memory.
   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

   // Without the checksum, LAST covers the cycle in which the final write
   // strobe is issued. As a result, done rises one cycle after that strobe.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
`ifdef PROG_LOADER_CHKSUM_EN
      S_CHK,
`else
      S_LAST,
`endif
      S_DONE
   } state_t;

   state_t       state_reg;
   state_t       state_next;

   logic [15:0]  len_reg;
   logic [15:0]  word_cnt_reg;
   logic [1:0]   byte_cnt_reg;
   logic [23:0]  shift_reg;
   logic [31:0]  wdata_reg;
   logic [31:0]  addr_reg;
   logic         we_reg;
   logic         err_reg;
`ifdef PROG_LOADER_CHKSUM_EN
   logic [7:0]   chk_reg;
`endif

   logic         rx_ready_next;
   logic         busy_next;
   logic         set_err;
   logic         accept;
   logic         start_ok;
   logic         word_done;
   logic         last_word;
   logic         oversize;
   logic [15:0]  len_full;

   assign accept    = rx_valid && rx_ready_next;
   assign start_ok  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
   assign word_done = accept && (state_reg == S_DATA) && (byte_cnt_reg == 2'd3);
   assign len_full  = {len_reg[15:8], rx_data};
   assign oversize  = {16'd0, len_full} > CAPACITY;
   assign last_word = ({1'b0, word_cnt_reg} + 17'd1) == {1'b0, len_reg};

   // State register; reset aborts any load in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic, handshake/busy decode, and error detection.
   always_comb begin
      state_next    = state_reg;
      rx_ready_next = 1'b0;
      busy_next     = 1'b0;
      set_err       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            rx_ready_next = 1'b1;
            busy_next     = 1'b1;
            if (rx_valid) state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            rx_ready_next = 1'b1;
            busy_next     = 1'b1;
            if (rx_valid) begin
               if (len_full == 16'd0) begin
`ifdef PROG_LOADER_CHKSUM_EN
                  state_next = S_CHK;
`else
                  state_next = S_DONE;
`endif
               end else if (oversize) begin
                  state_next = S_DONE;
                  set_err    = 1'b1;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            rx_ready_next = 1'b1;
            busy_next     = 1'b1;
            if (rx_valid && (byte_cnt_reg == 2'd3) && last_word) begin
`ifdef PROG_LOADER_CHKSUM_EN
               state_next = S_CHK;
`else
               state_next = S_LAST;
`endif
            end
         end
`ifdef PROG_LOADER_CHKSUM_EN
         S_CHK: begin
            rx_ready_next = 1'b1;
            busy_next     = 1'b1;
            if (rx_valid) begin
               state_next = S_DONE;
               if (rx_data != chk_reg) set_err = 1'b1;
            end
         end
`else
         S_LAST: begin
            busy_next  = 1'b1;
            state_next = S_DONE;
         end
`endif
         S_DONE: begin
            if (start) state_next = S_LEN_HI;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: length capture, word assembly, write strobe and sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_reg      <= 16'd0;
         word_cnt_reg <= 16'd0;
         byte_cnt_reg <= 2'd0;
         shift_reg    <= 24'd0;
         wdata_reg    <= 32'd0;
         addr_reg     <= BASE_ADDR;
         we_reg       <= 1'b0;
         err_reg      <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
         chk_reg      <= 8'd0;
`endif
      end else begin
         we_reg <= word_done;
         if (start_ok) begin
            err_reg      <= 1'b0;
            word_cnt_reg <= 16'd0;
            byte_cnt_reg <= 2'd0;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_reg      <= 8'd0;
`endif
         end else if (set_err) begin
            err_reg <= 1'b1;
         end
         if (accept && (state_reg == S_LEN_HI)) len_reg[15:8] <= rx_data;
         if (accept && (state_reg == S_LEN_LO)) len_reg[7:0]  <= rx_data;
         if (accept && (state_reg == S_DATA)) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_reg      <= chk_reg ^ rx_data;
`endif
            if (byte_cnt_reg == 2'd3) begin
               wdata_reg    <= {shift_reg, rx_data};
               addr_reg     <= BASE_ADDR + 32'({word_cnt_reg, 2'b00});
               word_cnt_reg <= word_cnt_reg + 16'd1;
            end else begin
               shift_reg <= {shift_reg[15:0], rx_data};
            end
         end
      end
   end

   assign rx_ready  = rx_ready_next;
   assign busy      = busy_next;
   assign done      = (state_reg == S_DONE);
   assign err       = err_reg;
   assign core_hold = !((state_reg == S_DONE) && !err_reg);
   assign im_we     = we_reg;
   assign im_addr   = addr_reg;
   assign im_wdata  = wdata_reg;

endmodule
